// File: rtl/i2s_tx_if.sv
// Stereo sample handshake between the voice output path (producer) and the I2S transmitter.
interface i2s_tx_if;
    localparam int unsigned SAMPLE_W = 24;

    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample_l, output sample_r, output sample_valid, input  sample_ready);
    modport slave  (input  sample_l, input  sample_r, input  sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 64-bclk frames, 24-bit samples left-justified in 32-bit slots with one-bit delay,
// fed from a single-pair holding buffer; a zero frame and an underrun pulse are sent when it is empty.
module i2s_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     rst_b,
    i2s_tx_if.slave  sif,
    output logic     bclk,
    output logic     lrclk,
    output logic     sdata,
    output logic     underrun
);
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned FRAME_W  = 64;
    localparam int unsigned FC_W     = 6;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned PAD_W    = 8;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]    div_q,    div_d;
    logic                bclk_q,   bclk_d;
    logic                lrclk_q,  lrclk_d;
    logic                sdata_q,  sdata_d;
    logic                under_q,  under_d;
    logic [FC_W-1:0]     fc_q,     fc_d;
    logic                ready_q,  ready_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic [FRAME_W-1:0]  shift_q,  shift_d;

    logic tick;
    logic fall;
    logic load;
    logic xfer;

    // Next-state: divider, bit clock, frame sequencing and holding buffer.
    always_comb begin
        div_d    = div_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        under_d  = 1'b0;
        fc_d     = fc_q;
        ready_d  = ready_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        shift_d  = shift_q;

        tick = (div_q == DIV_MAX);
        fall = tick & bclk_q;
        load = fall & (fc_q == {FC_W{1'b1}});
        xfer = sif.sample_valid & ready_q;

        if (tick) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end

        if (fall) begin
            fc_d    = fc_q + FC_W'(1);
            lrclk_d = fc_d[FC_W-1];
            if (load) begin
                sdata_d = 1'b0;
                if (!ready_q) begin
                    shift_d = {hold_l_q, PAD_W'(0), hold_r_q, PAD_W'(0)};
                    ready_d = 1'b1;
                end else begin
                    shift_d = '0;
                    under_d = 1'b1;
                end
            end else begin
                sdata_d = shift_q[FRAME_W-1];
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end

        // An empty-buffer load leaves ready_q high, so a same-cycle capture is kept for the next frame.
        if (xfer) begin
            hold_l_d = sif.sample_l;
            hold_r_d = sif.sample_r;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            div_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b1;
            sdata_q  <= 1'b0;
            under_q  <= 1'b0;
            fc_q     <= {FC_W{1'b1}};
            ready_q  <= 1'b1;
            hold_l_q <= '0;
            hold_r_q <= '0;
            shift_q  <= '0;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            under_q  <= under_d;
            fc_q     <= fc_d;
            ready_q  <= ready_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            shift_q  <= shift_d;
        end
    end

    assign sif.sample_ready = ready_q;
    assign bclk             = bclk_q;
    assign lrclk            = lrclk_q;
    assign sdata            = sdata_q;
    assign underrun         = under_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at CLK_DIV=4: timing derived from clk edges counted since reset release.
module tb_i2s_tx;
    localparam int unsigned CLK_DIV = 4;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;
    logic bclk;
    logic lrclk;
    logic sdata;
    logic underrun;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    i2s_tx_if sif ();

    i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .sif      (sif),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_b = 1'b0;
        sif.sample_valid = 1'b0;
        sif.sample_l = '0;
        sif.sample_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        e = 0;
    endtask

    // Frame counter value after clk edge ev (first fall event lands on edge 8).
    function automatic int fc_at(input int ev);
        if (ev < 8) return 63;
        return ((ev - 8) / 8) % 64;
    endfunction

    function automatic logic exp_bit(input int fc, input logic [23:0] l, input logic [23:0] r);
        if (fc >= 1 && fc <= 24) return l[24-fc];
        if (fc >= 33 && fc <= 56) return r[56-fc];
        return 1'b0;
    endfunction

    function automatic logic [23:0] pl(input int k);
        return 24'(32'h100001 + k * 32'h010101);
    endfunction

    function automatic logic [23:0] pr(input int k);
        return 24'(32'hF0F0F0 - k * 32'h020202);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        sif.sample_valid = 1'b0;
        rst_b = 1'b0;
        #1;
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL reset_lrclk got %b want 1", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata got %b want 0", sdata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
        checks++; if (sif.sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", sif.sample_ready); end
    endtask

    task automatic test_idle();
        int bad_u = 0, bad_s = 0, bad_b = 0, bad_lr = 0, nu = 0;
        logic exp_u, exp_b, exp_lr;
        reset_release();
        while (e < 1040) begin
            tick();
            if (e == 4) begin
                checks++; if (bclk !== 1'b1) begin errors++; $display("FAIL idle_first_bclk_rise got %b want 1", bclk); end
            end
            if (e == 7) begin
                checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL idle_underrun_e7 got %b want 0", underrun); end
            end
            if (e == 8) begin
                checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_underrun_e8 got %b want 1", underrun); end
                checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL idle_lrclk_e8 got %b want 0", lrclk); end
            end
            exp_u  = (e >= 8) && ((e - 8) % 512 == 0);
            exp_b  = 1'((e / 4) % 2);
            exp_lr = (fc_at(e) >= 32);
            if (underrun !== exp_u) bad_u++;
            if (underrun === 1'b1) nu++;
            if (sdata !== 1'b0) bad_s++;
            if (bclk !== exp_b) bad_b++;
            if (lrclk !== exp_lr) bad_lr++;
        end
        checks++; if (bad_u != 0) begin errors++; $display("FAIL idle_underrun_timing bad %0d want 0", bad_u); end
        checks++; if (nu != 3) begin errors++; $display("FAIL idle_underrun_count got %0d want 3", nu); end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL idle_sdata_zero bad %0d want 0", bad_s); end
        checks++; if (bad_b != 0) begin errors++; $display("FAIL idle_bclk_period bad %0d want 0", bad_b); end
        checks++; if (bad_lr != 0) begin errors++; $display("FAIL idle_lrclk_vs_fc bad %0d want 0", bad_lr); end
    endtask

    task automatic test_single_pair();
        logic rise_s [0:129];
        logic rise_lr[0:129];
        logic [23:0] l0, r0, l1, r1;
        logic prev_b = 1'b0;
        logic exp_s, exp_lr;
        int n = 0, bad_s = 0, bad_lr = 0, fc;
        reset_release();
        sif.sample_l = 24'hA5A5A5;
        sif.sample_r = 24'h123456;
        sif.sample_valid = 1'b1;
        tick();
        checks++; if (sif.sample_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_xfer got %b want 0", sif.sample_ready); end
        sif.sample_valid = 1'b0;
        while (e < 1040) begin
            tick();
            if (bclk === 1'b1 && prev_b === 1'b0 && n < 130) begin
                rise_s[n]  = sdata;
                rise_lr[n] = lrclk;
                n++;
            end
            prev_b = bclk;
            if (e == 8) begin
                checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_no_underrun got %b want 0", underrun); end
            end
            if (e == 520) begin
                checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL single_second_underrun got %b want 1", underrun); end
            end
        end
        checks++; if (n != 130) begin errors++; $display("FAIL single_rise_count got %0d want 130", n); end
        for (int i = 0; i < 24; i++) begin
            l0[23-i] = rise_s[2+i];
            r0[23-i] = rise_s[34+i];
            l1[23-i] = rise_s[66+i];
            r1[23-i] = rise_s[98+i];
        end
        for (int i = 0; i < 130; i++) begin
            fc     = (i == 0) ? 63 : (i - 1) % 64;
            exp_lr = (fc >= 32);
            exp_s  = (i >= 1 && i <= 64) ? exp_bit(fc, 24'hA5A5A5, 24'h123456) : 1'b0;
            if (rise_lr[i] !== exp_lr) bad_lr++;
            if (rise_s[i] !== exp_s) bad_s++;
        end
        checks++; if (l0 !== 24'hA5A5A5) begin errors++; $display("FAIL single_left got %h want a5a5a5", l0); end
        checks++; if (r0 !== 24'h123456) begin errors++; $display("FAIL single_right got %h want 123456", r0); end
        checks++; if (l1 !== 24'h0) begin errors++; $display("FAIL single_next_left got %h want 000000", l1); end
        checks++; if (r1 !== 24'h0) begin errors++; $display("FAIL single_next_right got %h want 000000", r1); end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL single_bitstream bad %0d want 0", bad_s); end
        checks++; if (bad_lr != 0) begin errors++; $display("FAIL single_lrclk_at_rise bad %0d want 0", bad_lr); end
    endtask

    task automatic test_back_to_back();
        int k = 0, nx = 0, nready = 0, bad_gap = 0, bad_s = 0, nu = 0, last_x = 0, f;
        logic xp, exp_s;
        reset_release();
        sif.sample_l = pl(0);
        sif.sample_r = pr(0);
        sif.sample_valid = 1'b1;
        while (e < 2056) begin
            xp = sif.sample_ready;
            tick();
            if (xp === 1'b1) begin
                if (nx >= 2 && (e - last_x) != 512) bad_gap++;
                last_x = e;
                nx++;
                k++;
                sif.sample_l = pl(k);
                sif.sample_r = pr(k);
            end
            if (sif.sample_ready === 1'b1) nready++;
            if (underrun === 1'b1) nu++;
            if (e >= 8) begin
                f = (e - 8) / 512;
                exp_s = exp_bit(fc_at(e), pl(f), pr(f));
                if (sdata !== exp_s) bad_s++;
            end
        end
        sif.sample_valid = 1'b0;
        checks++; if (nx != 5) begin errors++; $display("FAIL stream_xfer_count got %0d want 5", nx); end
        checks++; if (nready != 5) begin errors++; $display("FAIL stream_ready_cycles got %0d want 5", nready); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL stream_xfer_spacing bad %0d want 0", bad_gap); end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL stream_sdata_order bad %0d want 0", bad_s); end
        checks++; if (nu != 0) begin errors++; $display("FAIL stream_underrun got %0d want 0", nu); end
    endtask

    task automatic test_edge_values();
        int bad_s = 0;
        reset_release();
        sif.sample_l = 24'h800000;
        sif.sample_r = 24'h7FFFFF;
        sif.sample_valid = 1'b1;
        tick();
        sif.sample_valid = 1'b0;
        while (e < 520) begin
            tick();
            if (e >= 8 && sdata !== exp_bit(fc_at(e), 24'h800000, 24'h7FFFFF)) bad_s++;
            if (e == 16) begin
                checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL edge_left_msb got %b want 1", sdata); end
            end
            if (e == 24) begin
                checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL edge_left_bit22 got %b want 0", sdata); end
            end
            if (e == 264) begin
                checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL edge_pad_fc32 got %b want 0", sdata); end
            end
            if (e == 272) begin
                checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL edge_right_msb got %b want 0", sdata); end
            end
            if (e == 280) begin
                checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL edge_right_bit22 got %b want 1", sdata); end
            end
            if (e == 456) begin
                checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL edge_right_lsb got %b want 1", sdata); end
            end
            if (e == 464) begin
                checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL edge_pad_fc57 got %b want 0", sdata); end
            end
        end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL edge_bitstream bad %0d want 0", bad_s); end
    endtask

    task automatic test_mid_reset();
        int bad_s = 0;
        reset_release();
        sif.sample_l = 24'h0F0F0F;
        sif.sample_r = 24'hFFFFFF;
        sif.sample_valid = 1'b1;
        tick();
        sif.sample_l = 24'h111111;
        sif.sample_r = 24'h222222;
        while (e < 332) begin
            tick();
            if (e == 9) sif.sample_valid = 1'b0;
        end
        checks++; if (sif.sample_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre_full got %b want 0", sif.sample_ready); end
        checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL midrst_pre_sdata got %b want 1", sdata); end
        checks++; if (bclk !== 1'b1) begin errors++; $display("FAIL midrst_pre_bclk got %b want 1", bclk); end
        #2;
        rst_b = 1'b0;
        #1;
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL midrst_bclk got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL midrst_lrclk got %b want 1", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL midrst_sdata got %b want 0", sdata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun got %b want 0", underrun); end
        checks++; if (sif.sample_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", sif.sample_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        e = 0;
        while (e < 520) begin
            tick();
            if (e == 1) begin
                checks++; if (sif.sample_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %b want 1", sif.sample_ready); end
            end
            if (e == 8) begin
                checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL midrst_first_underrun got %b want 1", underrun); end
            end
            if (sdata !== 1'b0) bad_s++;
        end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL midrst_zero_frame bad %0d want 0", bad_s); end
    endtask

    initial begin
        sif.sample_valid = 1'b0;
        sif.sample_l = '0;
        sif.sample_r = '0;
        test_reset();
        test_idle();
        test_single_pair();
        test_back_to_back();
        test_edge_values();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, sets clk cycles per bclk half-period; legal range 2..255.
REQ-002 clk  input  1  system clock, the single clock domain; all state updates on posedge clk.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 sample_l  input  24  left-channel sample, two's complement, taken from the voice output path.
REQ-005 sample_r  input  24  right-channel sample, two's complement.
REQ-006 sample_valid  input  1  producer asserts when sample_l/sample_r hold a new stereo pair.
REQ-007 sample_ready  output  1  block can accept a pair this cycle.
REQ-008 bclk  output  1  serial bit clock to DAC.
REQ-009 lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-010 sdata  output  1  serial data, MSB first.
REQ-011 underrun  output  1  one-cycle pulse when a frame starts with no pair buffered.

Function
REQ-012 Divider counter runs 0..CLK_DIV-1; in the cycle it equals CLK_DIV-1 it wraps to 0 and bclk toggles.
REQ-013 A "fall event" is the cycle in which bclk toggles 1->0; lrclk, sdata and the frame counter change only on fall events.
REQ-014 Frame counter fc (6 bits) increments by 1 on each fall event, wrapping 63->0; 64 bclk periods per frame, 32-bit slot per channel.
REQ-015 lrclk = 0 while fc is 0..31 and 1 while fc is 32..63, updated together with fc.
REQ-016 sdata, with one-bit I2S delay: fc=1..24 carries L[23..0]; fc=25..32 drive 0; fc=33..56 carry R[23..0]; fc=57..63 and fc=0 drive 0.
REQ-017 Holding buffer is one stereo pair plus a full flag; sample_ready = not full.
REQ-018 Handshake: a transfer occurs in a cycle with sample_valid=1 and sample_ready=1; the pair is captured and full is set next cycle.
REQ-019 sample_valid while sample_ready=0 is ignored; producer holds data until a transfer occurs.
REQ-020 Frame load: on the fall event where fc wraps 63->0, the shift register loads the holding pair and full clears.
REQ-021 If full=0 at frame load: shift register loads zeros for both channels, underrun pulses high for exactly that cycle.
REQ-022 Transfer and frame load cannot collide, because transfer requires full=0 and load of real data requires full=1; if a transfer and an empty-buffer frame load happen in the same cycle, the zero frame is sent, underrun pulses, and the captured pair is kept for the next frame.
REQ-023 Sample bits are passed through unaltered; no rounding, saturation or sign extension.
REQ-024 Frame rate = f_clk / (2 * CLK_DIV * 64).

Reset
REQ-025 While rst_b=0: bclk=0, lrclk=1, sdata=0, underrun=0, divider=0, fc=63, full=0, shift register=0; sample_ready is therefore 1.
REQ-026 After rst_b rises: first bclk rise occurs on the CLK_DIV-th clk edge; the first fall event follows CLK_DIV edges later, takes fc to 0 and performs a frame load.
REQ-027 Reset asserted mid-frame aborts the frame and discards any buffered pair immediately; no partial state survives.

Verification
REQ-028 Reset release, no samples, CLK_DIV=4 -> bclk period 8 clk; underrun pulses at clk edge 8 and then every 512 clk; sdata constantly 0.
REQ-029 Before the first load, give one transfer L=24'hA5A5A5, R=24'h123456 -> on the DAC side, decoded on bclk rise, left=A5A5A5 and right=123456; next frame is zero with underrun.
REQ-030 Hold sample_valid=1 continuously with an incrementing L/R -> exactly one transfer per 512 clk; sample_ready is high for 1 cycle after each load; every value appears in order, none skipped; no underrun after the first frame.
REQ-031 Edge values L=24'h800000, R=24'h7FFFFF -> sdata bit fc=1 is 1 then 23 zeros; right slot fc=33 is 0 then 23 ones; fc=25..32 and 57..0 are 0.
REQ-032 Assert rst_b=0 at fc=40 with the buffer full -> all outputs are at their reset values within the same cycle; after release sample_ready=1 and the first frame is zero with underrun.
REQ-033 Check lrclk against fc throughout: lrclk toggles only on fall events, once every 32 bclk periods, one bclk before each channel MSB.
